// File: rtl/serial_sub_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sub_pkg
// Shared types and constants for the bit-serial subtraction controller.
//   state_e        : controller state encoding (2'd3 is unused and recovers
//                    to IDLE on the next clock edge)
//   SUB_WIDTH_DEF  : default operand/result width
// ----------------------------------------------------------------------------
package sub_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : sub_pkg

// File: rtl/serial_sub_ctrl_if.sv
// ----------------------------------------------------------------------------
// serial_sub_ctrl_if
// Request/result bundle between a requester and serial_sub_ctrl.
//   start : request, sampled only while the controller is idle
//   a, b  : minuend / subtrahend, captured on an accepted start
//   bin   : initial borrow-in, captured on an accepted start
//   busy  : controller is running or completing
//   done  : one-cycle completion pulse
//   diff  : registered result a - b - bin (mod 2^WIDTH)
//   bout  : registered final borrow-out
// Modports: master = requester side, slave = controller side.
// ----------------------------------------------------------------------------
interface serial_sub_ctrl_if
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface : serial_sub_ctrl_if

// File: rtl/serial_sub_ctrl_fs_cell.sv
// ----------------------------------------------------------------------------
// fs_cell
// Purely combinational one-bit full subtractor: computes a - b - bi.
//   a, b, bi : operand bits and incoming borrow
//   d        : difference bit
//   bo       : outgoing borrow (1 when a < b + bi)
// ----------------------------------------------------------------------------
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  // Borrow out when a=0,b=1, or when a==b and a borrow is already pending.
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule : fs_cell

// File: rtl/serial_sub_ctrl.sv
// ----------------------------------------------------------------------------
// serial_sub_ctrl
// Bit-serial subtraction controller. One fs_cell is time-multiplexed over
// WIDTH-bit operands, LSB first, one bit per clock; the borrow rides between
// cycles in a flop.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_sub_ctrl_if slave (start/a/b/bin in, busy/done/diff/bout out)
// Timing: start accepted at edge E0, bits processed at E1..E_WIDTH, done high
// for the cycle after E_WIDTH, back in IDLE one edge later.
// ----------------------------------------------------------------------------
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_sub_ctrl_if.slave   bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   sd_q, sd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               brw_q, brw_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;

  logic               cell_d;
  logic               cell_bo;

  // The single subtractor cell always looks at the current LSBs.
  fs_cell u_cell (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .bi (brw_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          brw_d   = bus.bin;
          cnt_d   = '0;
          sd_d    = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        busy_d = 1'b1;
        // Result bits enter at the MSB so after WIDTH shifts the LSB has
        // reached bit 0.
        sd_d   = {cell_d, sd_q[WIDTH-1:1]};
        sa_d   = {1'b0, sa_q[WIDTH-1:1]};
        sb_d   = {1'b0, sb_q[WIDTH-1:1]};
        brw_d  = cell_bo;
        if (cnt_q == CNT_LAST) begin
          // Counter stops here rather than wrapping; it is reloaded on accept.
          diff_d  = {cell_d, sd_q[WIDTH-1:1]};
          bout_d  = cell_bo;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        // Unused encoding: recover quietly to IDLE.
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule : serial_sub_ctrl

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial subtraction controller. Sequences a single one-bit full-subtractor cell over WIDTH-bit operands, LSB first, one bit per clock. The borrow is carried between cycles in a flop. Sits between a requester (start/done handshake) and the subtractor cell, giving multi-bit A - B - Bin at the area cost of one cell.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32
CNT_W, $clog2(WIDTH), bit counter width; derived, not overridden

Ports:
clk    in   1      rising-edge clock
rst_n  in   1      asynchronous active-low reset
start  in   1      request; sampled only in IDLE
a      in   WIDTH  minuend; captured on accepted start
b      in   WIDTH  subtrahend; captured on accepted start
bin    in   1      initial borrow-in; captured on accepted start
busy   out  1      high in RUN and DONE
done   out  1      one-cycle completion pulse
diff   out  WIDTH  result a - b - bin, modulo 2^WIDTH
bout   out  1      final borrow-out (1 = a < b + bin, unsigned)

Behaviour:
- Reset: while rst_n=0, async force state=IDLE, busy=0, done=0, diff=0, bout=0, and all internal shift/counter/borrow regs to 0. Reset mid-RUN abandons the operation. No partial result is exposed.
- States:
  - IDLE: busy=0, done=0. On an edge with start=1:
    - load sa<=a, sb<=b, brw<=bin, cnt<=0, sd<=0
    - go to RUN.
  - RUN: busy=1. Each edge:
    - the cell computes d = sa[0]^sb[0]^brw and bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&brw)
    - sd <= {d, sd[WIDTH-1:1]}; sa, sb shift right by 1; brw <= bo; cnt <= cnt+1
    - when cnt==WIDTH-1: also load diff <= {d, sd[WIDTH-1:1]}, bout <= bo, and go to DONE.
  - DONE: busy=1, done=1 for exactly this one cycle. Next edge goes to IDLE unconditionally.
- Latency: start sampled at edge E0. Bits are processed at edges E1..E_WIDTH. done is high in the cycle following E_WIDTH. Minimum start-to-start period is WIDTH+2 cycles.
- diff/bout are registered outputs. They change only on the RUN->DONE edge and hold until the next completion or reset.
- start in RUN or DONE is ignored, not queued. start held high continuously is accepted on the first IDLE edge after DONE.
- a/b/bin may change freely after acceptance; internal copies are used.
- Counter never wraps: exits at WIDTH-1 and is reloaded on the next accept.
- No X propagation: all regs are reset.

Decomposition:
- Package sub_pkg:
  - state enum {IDLE=2'd0, RUN=2'd1, DONE=2'd2}; value 2'd3 is illegal and decodes to IDLE on the next edge
  - default width constant SUB_WIDTH_DEF=8
- One sub-module: fs_cell, a purely combinational 1-bit full subtractor (a, b, bi -> d, bo), instantiated once. The controller owns all state.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start 1 cycle -> busy 1 for 9 cycles, done pulse once at cycle 9 after accept, diff=0x02, bout=0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0.
- Exhaustive 1-bit sweep with WIDTH=2, all 32 (a, b, bin) combos -> diff==(a-b-bin)&3, bout==(a<b+bin), checked against a reference model.
- Start pulsed in RUN cycle 3 and in the DONE cycle with different operands -> ignored; diff reflects only the first operation. Start held high permanently -> back-to-back ops every 10 cycles.
- rst_n low for 1 cycle during RUN cycle 4 (async, mid-cycle) -> outputs 0 immediately, state IDLE, no done pulse. A following op completes correctly.
- Operands changed every cycle during RUN -> result matches the values captured at accept.
